// File: rtl/imem_loader.sv
// Boot loader: turns a framed, checksummed byte stream into big-endian word writes
// to instruction memory and keeps the core in reset until a good program has arrived.
module imem_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_write,
  output logic [31:0]       mem_address,
  output logic [31:0]       mem_write_data,
  output logic              cpu_reset,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [2:0] S_LEN_HI = 3'd0;
  localparam logic [2:0] S_LEN_LO = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_CSUM   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_ERR    = 3'd5;

  localparam logic [16:0] MAX_WORDS = 17'(1 << ADDR_W);

  logic [2:0]      state_q, state_d;
  logic [15:0]     len_q, len_d;
  logic [1:0]      phase_q, phase_d;
  logic [23:0]     shift_q, shift_d;
  logic [7:0]      csum_q, csum_d;
  logic [ADDR_W:0] count_q, count_d;
  logic            mem_write_q, mem_write_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            cpu_reset_q, cpu_reset_d;
  logic            done_q, done_d;
  logic            error_q, error_d;

  logic            accept;
  logic [15:0]     new_len;
  logic [16:0]     next_count;

  assign in_ready = !reset && (state_q == S_LEN_HI || state_q == S_LEN_LO ||
                               state_q == S_DATA   || state_q == S_CSUM);
  assign accept     = in_valid && in_ready;
  assign new_len    = {len_q[15:8], in_data};
  assign next_count = 17'(count_q) + 17'd1;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    phase_d     = phase_q;
    shift_d     = shift_q;
    csum_d      = csum_q;
    count_d     = count_q;
    mem_write_d = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_reset_d = cpu_reset_q;
    done_d      = done_q;
    error_d     = error_q;

    case (state_q)
      S_LEN_HI: begin
        if (accept) begin
          len_d[15:8] = in_data;
          state_d     = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          len_d[7:0] = in_data;
          if (new_len == 16'd0) begin
            state_d = S_CSUM;
          end else if ({1'b0, new_len} > MAX_WORDS) begin
            state_d = S_ERR;
            error_d = 1'b1;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          csum_d  = csum_q ^ in_data;
          phase_d = phase_q + 2'd1;
          shift_d = {shift_q[15:0], in_data};
          // Fourth byte completes the word; the write is registered for next cycle.
          if (phase_q == 2'd3) begin
            mem_write_d = 1'b1;
            addr_d      = 32'(count_q[ADDR_W-1:0]) << 2;
            wdata_d     = {shift_q, in_data};
            count_d     = count_q + (ADDR_W+1)'(1);
            if (next_count == {1'b0, len_q}) begin
              state_d = S_CSUM;
            end
          end
        end
      end
      S_CSUM: begin
        if (accept) begin
          if (in_data == csum_q) begin
            state_d     = S_DONE;
            done_d      = 1'b1;
            cpu_reset_d = 1'b0;
          end else begin
            state_d = S_ERR;
            error_d = 1'b1;
          end
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_LEN_HI;
      len_q       <= '0;
      phase_q     <= '0;
      shift_q     <= '0;
      csum_q      <= '0;
      count_q     <= '0;
      mem_write_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      phase_q     <= phase_d;
      shift_q     <= shift_d;
      csum_q      <= csum_d;
      count_q     <= count_d;
      mem_write_q <= mem_write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign mem_write      = mem_write_q;
  assign mem_address    = addr_q;
  assign mem_write_data = wdata_q;
  assign cpu_reset      = cpu_reset_q;
  assign done           = done_q;
  assign error          = error_q;
  assign words_loaded   = count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: frames are built from word lists and the
// expected writes, checksum and final status are derived from those lists.
module tb_imem_loader;

  localparam int ADDR_W    = 10;
  localparam int MAX_WORDS = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_write;
  logic [31:0]       mem_address;
  logic [31:0]       mem_write_data;
  logic              cpu_reset;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   words_loaded;

  int checks = 0;
  int passed = 0;

  logic [31:0] progWords[$];
  logic [31:0] txWords[$];

  bit          capture = 1'b0;
  logic [31:0] capAddr[$];
  logic [31:0] capData[$];
  logic [ADDR_W:0] capCount[$];

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_write_data(mem_write_data),
    .cpu_reset     (cpu_reset),
    .done          (done),
    .error         (error),
    .words_loaded  (words_loaded)
  );

  always #5 clk = ~clk;

  // Every cycle with the strobe high is recorded as one memory write.
  always @(negedge clk) begin
    if (capture && mem_write === 1'b1) begin
      capAddr.push_back(mem_address);
      capData.push_back(mem_write_data);
      capCount.push_back(words_loaded);
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic send_byte(input logic [7:0] b, input int maxGap);
    int gap;
    gap = (maxGap > 0) ? int'($urandom_range(maxGap, 0)) : 0;
    repeat (gap) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Sends one frame built from txWords and checks writes and status against the model.
  task automatic run_frame(input logic [15:0] n, input logic [7:0] csumFlip,
                           input int maxGap, input string name);
    logic [7:0]  csum;
    logic [31:0] w;
    bit          overflow;
    bit          expDone;
    int          expWrites;
    int          nInt;

    nInt     = int'(n);
    overflow = nInt > MAX_WORDS;
    csum     = 8'h00;
    if (!overflow) begin
      for (int i = 0; i < nInt; i++) begin
        w = txWords[i];
        for (int k = 0; k < 4; k++) csum ^= w[31-8*k -: 8];
      end
    end
    expDone   = !overflow && (csumFlip == 8'h00);
    expWrites = overflow ? 0 : nInt;

    capAddr.delete();
    capData.delete();
    capCount.delete();
    capture = 1'b1;

    send_byte(n[15:8], maxGap);
    send_byte(n[7:0], maxGap);

    if (overflow) begin
      checks++;
      if (error !== 1'b1) $display("[TB] FAIL %s error_after_len: got %b expected 1", name, error);
      else passed++;
    end else begin
      for (int i = 0; i < nInt; i++) begin
        w = txWords[i];
        for (int k = 0; k < 4; k++) send_byte(w[31-8*k -: 8], maxGap);
      end
      checks++;
      if (done !== 1'b0 || error !== 1'b0)
        $display("[TB] FAIL %s status_before_csum: got done=%b error=%b expected done=0 error=0", name, done, error);
      else passed++;
      send_byte(csum ^ csumFlip, maxGap);
      checks++;
      if (done !== expDone || error !== !expDone || cpu_reset !== !expDone)
        $display("[TB] FAIL %s status_after_csum: got done=%b error=%b cpu_reset=%b expected done=%b error=%b cpu_reset=%b",
                 name, done, error, cpu_reset, expDone, !expDone, !expDone);
      else passed++;
    end

    idle(3);
    capture = 1'b0;

    checks++;
    if (capAddr.size() != expWrites)
      $display("[TB] FAIL %s write_count: got %0d expected %0d", name, capAddr.size(), expWrites);
    else passed++;

    for (int i = 0; i < expWrites && i < capAddr.size(); i++) begin
      checks++;
      if (capAddr[i] !== 32'(i) * 32'd4 || capData[i] !== txWords[i] ||
          capCount[i] !== (ADDR_W+1)'(i + 1))
        $display("[TB] FAIL %s write_%0d: got addr=%h data=%h count=%0d expected addr=%h data=%h count=%0d",
                 name, i, capAddr[i], capData[i], capCount[i], 32'(i) * 32'd4, txWords[i], i + 1);
      else passed++;
    end

    checks++;
    if (words_loaded !== (ADDR_W+1)'(expWrites))
      $display("[TB] FAIL %s words_loaded: got %0d expected %0d", name, words_loaded, expWrites);
    else passed++;

    checks++;
    if (done !== expDone || error !== !expDone || cpu_reset !== !expDone || in_ready !== 1'b0)
      $display("[TB] FAIL %s final_status: got done=%b error=%b cpu_reset=%b in_ready=%b expected done=%b error=%b cpu_reset=%b in_ready=0",
               name, done, error, cpu_reset, in_ready, expDone, !expDone, !expDone);
    else passed++;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'($urandom);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) $display("[TB] FAIL reset in_ready: got %b expected 0", in_ready);
    else passed++;
    checks++;
    if (mem_write !== 1'b0 || mem_address !== 32'h0 || mem_write_data !== 32'h0)
      $display("[TB] FAIL reset mem_port: got write=%b addr=%h data=%h expected 0/0/0", mem_write, mem_address, mem_write_data);
    else passed++;
    checks++;
    if (cpu_reset !== 1'b1 || done !== 1'b0 || error !== 1'b0 || words_loaded !== '0)
      $display("[TB] FAIL reset status: got cpu_reset=%b done=%b error=%b words=%0d expected 1/0/0/0",
               cpu_reset, done, error, words_loaded);
    else passed++;
    reset    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) $display("[TB] FAIL reset in_ready_after: got %b expected 1", in_ready);
    else passed++;
  endtask

  task automatic test_isort();
    txWords = progWords;
    run_frame(16'h001F, 8'h00, 0, "isort");
  endtask

  task automatic test_empty();
    pulse_reset();
    txWords.delete();
    run_frame(16'h0000, 8'h00, 0, "empty");
  endtask

  task automatic test_bad_csum();
    pulse_reset();
    txWords.delete();
    txWords.push_back(32'h34080000);
    run_frame(16'h0001, 8'h3C, 0, "bad_csum");
  endtask

  task automatic test_overflow();
    pulse_reset();
    txWords.delete();
    run_frame(16'h0401, 8'h00, 0, "overflow");
    pulse_reset();
    txWords.delete();
    for (int i = 0; i < MAX_WORDS; i++) txWords.push_back(32'($urandom));
    run_frame(16'h0400, 8'h00, 0, "full_size");
  endtask

  task automatic test_gaps();
    pulse_reset();
    txWords = progWords;
    run_frame(16'h001F, 8'h00, 5, "gaps");
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] w;
    pulse_reset();
    send_byte(8'h00, 0);
    send_byte(8'h1F, 0);
    for (int j = 0; j < 6; j++) begin
      w = progWords[j / 4];
      send_byte(w[31-8*(j%4) -: 8], 0);
    end
    reset    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (words_loaded !== '0 || done !== 1'b0 || error !== 1'b0 || cpu_reset !== 1'b1)
      $display("[TB] FAIL midreset status: got words=%0d done=%b error=%b cpu_reset=%b expected 0/0/0/1",
               words_loaded, done, error, cpu_reset);
    else passed++;
    txWords = progWords;
    run_frame(16'h001F, 8'h00, 2, "restart");
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;

    progWords.push_back(32'h34080000);
    for (int i = 1; i < 30; i++) progWords.push_back(32'($urandom));
    progWords.push_back(32'h1000FFFF);

    test_reset();
    test_isort();
    test_empty();
    test_bad_csum();
    test_overflow();
    test_gaps();
    test_reset_mid_frame();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
